epm_ym_bus_sequencer: RTL and testbench

EPM_YM_BUS_SEQUENCER -- requirements
Module: ym_bus_sequencer

---
 rtl/epm_ym_bus_sequencer.sv | 121 ++++++++++++
 tb/tb_epm_ym_bus_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/epm_ym_bus_sequencer.sv
// Queued write sequencer for one or two AY/YM PSGs (TurboSound): each request becomes
// a SETUP / PULSE / HOLD bus cycle on BDIR/BC1 with chip select and data held steady around the strobe.
module epm_ym_bus_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_kind,
  input  logic       req_chip,
  input  logic [7:0] req_data,
  output logic       bdir,
  output logic       bc1,
  output logic       ym_0,
  output logic       ym_1,
  output logic [7:0] psg_data,
  output logic       psg_data_oe,
  output logic       busy,
  output logic [3:0] fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic       kind;
    logic       chip;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  req_t             mem [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  state_t           state;
  logic [3:0]       phase;
  logic             kind_r;
  logic             push, pop, to_idle;
  logic [3:0]       nxt_level;

  assign push = req_valid && req_ready;
  assign pop  = (state == IDLE) && (fifo_level != 4'd0);
  assign head = mem[rd_ptr];

  always_comb begin
    nxt_level = fifo_level + {3'b000, push} - {3'b000, pop};
    to_idle   = ((state == IDLE) && !pop) || ((state == HOLD) && (phase == 4'd0));
  end

  // Queue storage is pure datapath; validity is tracked by fifo_level alone.
  always_ff @(posedge cpu_clock) begin
    if (push) mem[wr_ptr] <= '{kind: req_kind, chip: req_chip, data: req_data};
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= 4'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= 4'd0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      kind_r      <= 1'b0;
      bdir        <= 1'b0;
      bc1         <= 1'b0;
      psg_data    <= 8'h00;
      psg_data_oe <= 1'b0;
      ym_0        <= 1'b0;
      ym_1        <= 1'b1;
    end else begin
      fifo_level <= nxt_level;
      req_ready  <= (nxt_level < 4'(FIFO_DEPTH));
      busy       <= !to_idle || (nxt_level != 4'd0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: begin
          // Chip select and data change only here, never alongside a strobe edge.
          if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            kind_r      <= head.kind;
            ym_0        <= head.chip;
            ym_1        <= ~head.chip;
            psg_data    <= head.data;
            psg_data_oe <= 1'b1;
            phase       <= 4'(SETUP_CYC - 1);
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (phase == 4'd0) begin
            bdir  <= 1'b1;
            bc1   <= ~kind_r;
            phase <= 4'(PULSE_CYC - 1);
            state <= PULSE;
          end else phase <= phase - 4'd1;
        end
        PULSE: begin
          if (phase == 4'd0) begin
            bdir  <= 1'b0;
            bc1   <= 1'b0;
            phase <= 4'(HOLD_CYC - 1);
            state <= HOLD;
          end else phase <= phase - 4'd1;
        end
        HOLD: begin
          if (phase == 4'd0) begin
            psg_data_oe <= 1'b0;
            state       <= IDLE;
          end else phase <= phase - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epm_ym_bus_sequencer.sv
// Directed bench for epm_ym_bus_sequencer: a negedge monitor logs every BDIR strobe,
// and the test sequence compares the log and sampled outputs with hand-derived values.
module tb_epm_ym_bus_sequencer;
  logic       cpu_clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0, req_kind = 1'b0, req_chip = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, bdir, bc1, ym_0, ym_1, psg_data_oe, busy;
  logic [7:0] psg_data;
  logic [3:0] fifo_level;

  epm_ym_bus_sequencer dut (
    .cpu_clock(cpu_clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_chip(req_chip), .req_data(req_data), .bdir(bdir), .bc1(bc1),
    .ym_0(ym_0), .ym_1(ym_1), .psg_data(psg_data), .psg_data_oe(psg_data_oe), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 cpu_clock = ~cpu_clock;

  int cyc = 0;
  always @(posedge cpu_clock) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe log and running protocol counters
  int         s_start [32];
  int         s_width [32];
  logic       s_bc1   [32];
  logic       s_ym0   [32];
  logic [7:0] s_data  [32];
  int         n_str = 0, ym_err = 0, glitch_err = 0, gap_cnt = 0, busy_falls = 0;
  int         cur_start = 0, cur_w = 0;
  logic       cur_bc1 = 1'b0, cur_ym0 = 1'b0;
  logic [7:0] cur_data = 8'h00;
  logic       bdir_q = 1'b0, bc1_q = 1'b0, ym0_q = 1'b0, busy_q = 1'b0, rst_q = 1'b0;
  logic [7:0] data_q = 8'h00;

  always @(negedge cpu_clock) begin
    if (bdir && !bdir_q) begin
      cur_start = cyc; cur_w = 0; cur_bc1 = bc1; cur_ym0 = ym_0; cur_data = psg_data;
    end
    if (bdir) cur_w++;
    if (!bdir && bdir_q && n_str < 32) begin
      s_start[n_str] = cur_start; s_width[n_str] = cur_w; s_bc1[n_str] = cur_bc1;
      s_ym0[n_str] = cur_ym0; s_data[n_str] = cur_data;
      n_str++;
    end
    if (ym_1 !== ~ym_0) ym_err++;
    if (reset && rst_q && (bdir !== bdir_q || bc1 !== bc1_q) &&
        (ym_0 !== ym0_q || psg_data !== data_q)) glitch_err++;
    if (busy && !psg_data_oe) gap_cnt++;
    if (busy_q && !busy) busy_falls++;
    bdir_q = bdir; bc1_q = bc1; ym0_q = ym_0; data_q = psg_data; busy_q = busy; rst_q = reset;
  end

  // Called right after a negedge; returns at the negedge following acceptance.
  task automatic push(input logic k, input logic c, input logic [7:0] d, output int t);
    int g = 0;
    while (!req_ready && g < 100) begin @(negedge cpu_clock); g++; end
    if (g >= 100) chk("push_ready", req_ready, 1);
    req_kind = k; req_chip = c; req_data = d; req_valid = 1'b1;
    @(negedge cpu_clock);
    req_valid = 1'b0;
    t = cyc;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin @(negedge cpu_clock); g++; end
    if (g >= 300) chk("idle_timeout", busy, 0);
    @(negedge cpu_clock);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge cpu_clock);
  endtask

  initial begin
    int t, t0, t1, tl, b, gb, fb, i, g;
    int acc_c [5];
    logic acc;

    // Reset state
    @(negedge cpu_clock);
    chk("rst_bdir", bdir, 0);       chk("rst_bc1", bc1, 0);
    chk("rst_data", psg_data, 8'h00); chk("rst_oe", psg_data_oe, 0);
    chk("rst_ym0", ym_0, 0);        chk("rst_ym1", ym_1, 1);
    chk("rst_busy", busy, 0);       chk("rst_ready", req_ready, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b1;
    @(negedge cpu_clock);
    chk("ready_after_rst", req_ready, 1);

    // Single address latch
    b = n_str;
    push(1'b0, 1'b0, 8'h07, t);
    chk("lat_level", fifo_level, 1);
    chk("lat_busy", busy, 1);
    @(negedge cpu_clock);
    chk("lat_setup_oe", psg_data_oe, 1);
    chk("lat_setup_bdir", bdir, 0);
    chk("lat_setup_data", psg_data, 8'h07);
    chk("lat_popped", fifo_level, 0);
    wait_idle();
    chk("lat_nstr", n_str - b, 1);
    chk("lat_delay", s_start[b] - t, 3);
    chk("lat_width", s_width[b], 4);
    chk("lat_bc1", s_bc1[b], 1);
    chk("lat_ym0", s_ym0[b], 0);
    chk("lat_sdata", s_data[b], 8'h07);
    chk("lat_keep_data", psg_data, 8'h07);
    chk("lat_idle_oe", psg_data_oe, 0);

    // TurboSound switch
    b = n_str;
    push(1'b1, 1'b1, 8'h3F, t0);
    push(1'b0, 1'b0, 8'h08, t1);
    wait_idle();
    chk("ts_nstr", n_str - b, 2);
    chk("ts_bc1_0", s_bc1[b], 0);   chk("ts_ym0_0", s_ym0[b], 1);
    chk("ts_data_0", s_data[b], 8'h3F);
    chk("ts_bc1_1", s_bc1[b+1], 1); chk("ts_ym0_1", s_ym0[b+1], 0);
    chk("ts_data_1", s_data[b+1], 8'h08);
    chk("ts_spacing", s_start[b+1] - s_start[b], 9);
    chk("ts_keep_ym1", ym_1, 1);

    // Queue full: fill while the lead transaction is in flight
    b = n_str;
    push(1'b0, 1'b1, 8'hA0, tl);
    wait_cyc(tl + 3);
    i = 0; g = 0;
    req_kind = 1'b1; req_chip = 1'b0; req_data = 8'h10; req_valid = 1'b1;
    while (i < 5 && g < 100) begin
      acc = req_ready;
      @(negedge cpu_clock); g++;
      if (acc) begin
        acc_c[i] = cyc; i++;
        if (i == 4) begin
          chk("full_level", fifo_level, 4);
          chk("full_ready", req_ready, 0);
        end
        req_data = 8'(8'h10 + i);
      end
    end
    req_valid = 1'b0;
    chk("full_accepts", i, 5);
    chk("full_5th_wait", acc_c[4] - acc_c[3], 4);
    wait_idle();
    chk("full_nstr", n_str - b, 6);
    chk("full_lead", s_data[b], 8'hA0);
    for (int k = 0; k < 5; k++) chk("full_order", s_data[b+1+k], 8'(8'h10 + k));

    // Push/pop at level 2, then back-to-back run
    b = n_str; gb = gap_cnt; fb = busy_falls;
    push(1'b1, 1'b0, 8'h21, t0);
    push(1'b1, 1'b1, 8'h22, t);
    push(1'b0, 1'b0, 8'h23, t);
    chk("pp_level_pre", fifo_level, 2);
    wait_cyc(t0 + 9);
    chk("pp_level_idle", fifo_level, 2);
    push(1'b1, 1'b0, 8'h24, t);
    chk("pp_when", t - t0, 10);
    chk("pp_level", fifo_level, 2);
    wait_idle();
    chk("b2b_nstr", n_str - b, 4);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", s_start[b+k] - s_start[b+k-1], 9);
    chk("b2b_gaps", gap_cnt - gb, 4);
    chk("b2b_busy_falls", busy_falls - fb, 1);
    chk("b2b_last_data", s_data[b+3], 8'h24);

    // Reset during PULSE
    push(1'b0, 1'b1, 8'h55, t);
    push(1'b1, 1'b1, 8'h66, t1);
    wait_cyc(t + 4);
    chk("mid_bdir_pre", bdir, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_bdir", bdir, 0);       chk("mid_bc1", bc1, 0);
    chk("mid_level", fifo_level, 0); chk("mid_ym0", ym_0, 0);
    chk("mid_data", psg_data, 8'h00);
    @(negedge cpu_clock);
    @(negedge cpu_clock);
    reset = 1'b1;
    @(negedge cpu_clock);
    chk("mid_ready", req_ready, 1);
    b = n_str;
    repeat (30) @(negedge cpu_clock);
    chk("mid_no_strobe", n_str - b, 0);
    chk("mid_busy", busy, 0);
    push(1'b1, 1'b0, 8'h77, t);
    wait_idle();
    chk("mid_new_nstr", n_str - b, 1);
    chk("mid_new_data", s_data[b], 8'h77);

    chk("ym1_complement", ym_err, 0);
    chk("strobe_vs_select", glitch_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
